// File: rtl/random_arrows_if.sv
// Bus bundle for random_arrows: step/enable/threshold in, press/fired out.
// Optional seed-load signals appear when RANDOM_ARROWS_SEED_LOAD_EN is defined.
interface random_arrows_if #(
  parameter int unsigned LFSR_W = 9,
  parameter int unsigned NUM_CH = 4
);
  logic              enable_i;
  logic              step_i;
  logic [LFSR_W-1:0] threshold_i;
`ifdef RANDOM_ARROWS_SEED_LOAD_EN
  logic              seed_load_i;
  logic [LFSR_W-1:0] seed_in_i;
`endif
  logic [NUM_CH-1:0] press_o;
  logic              fired_o;

`ifdef RANDOM_ARROWS_SEED_LOAD_EN
  modport master (output enable_i, step_i, threshold_i, seed_load_i, seed_in_i,
                  input  press_o, fired_o);
  modport slave  (input  enable_i, step_i, threshold_i, seed_load_i, seed_in_i,
                  output press_o, fired_o);
`else
  modport master (output enable_i, step_i, threshold_i,
                  input  press_o, fired_o);
  modport slave  (input  enable_i, step_i, threshold_i,
                  output press_o, fired_o);
`endif
endinterface

// File: rtl/random_arrows.sv
// Multi-lane random arrow generator: one Fibonacci LFSR per lane, sampled on
// each accepted beat step; lanes below threshold fire, subject to a per-lane
// cooldown and a cap on simultaneous presses (lowest lane index wins).
// Optional feature macro: RANDOM_ARROWS_SEED_LOAD_EN (runtime seed reload).
module random_arrows #(
  parameter int unsigned LFSR_W    = 9,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEED_BASE = 'h0A5,
  parameter int unsigned GAP_MIN   = 2,
  parameter int unsigned MAX_SIMUL = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  random_arrows_if.slave bus
);
  localparam int unsigned CW    = (GAP_MIN == 0) ? 1 : $clog2(GAP_MIN + 1);
  localparam int unsigned CNT_W = $clog2(NUM_CH + 1);
  localparam int unsigned TAP_MASK = (LFSR_W == 8)  ? 'h00B8 :
                                     (LFSR_W == 9)  ? 'h0110 :
                                     (LFSR_W == 10) ? 'h0240 : 'hD008;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(TAP_MASK);

  logic [LFSR_W-1:0] lfsr_q [NUM_CH];
  logic [LFSR_W-1:0] lfsr_d [NUM_CH];
  logic [CW-1:0]     cool_q [NUM_CH];
  logic [CW-1:0]     cool_d [NUM_CH];
  logic [NUM_CH-1:0] press_q, press_d;
  logic              fired_q;
  logic [CNT_W-1:0]  granted;
  logic              accept;

  // Per-lane reset seed: base with lane index folded into bits above bit 0.
  function automatic logic [LFSR_W-1:0] seed_of(input int unsigned i);
    return LFSR_W'(SEED_BASE) ^ LFSR_W'(i << 1);
  endfunction

  // One shift-left step with XOR feedback into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & TAPS)};
  endfunction

  assign accept = bus.step_i && bus.enable_i;

  // Candidate selection, capped grant, cooldown and LFSR advance.
  always_comb begin
    press_d = '0;
    granted = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lfsr_d[i] = lfsr_q[i];
      cool_d[i] = cool_q[i];
    end
`ifdef RANDOM_ARROWS_SEED_LOAD_EN
    if (bus.seed_load_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lfsr_d[i] = (bus.seed_in_i ^ LFSR_W'(i << 1)) | LFSR_W'(1);
        cool_d[i] = '0;
      end
    end else
`endif
    if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((lfsr_q[i] < bus.threshold_i) && (cool_q[i] == '0) &&
            (granted < CNT_W'(MAX_SIMUL))) begin
          press_d[i] = 1'b1;
          granted    = granted + CNT_W'(1);
          cool_d[i]  = CW'(GAP_MIN);
        end else if (cool_q[i] != '0) begin
          cool_d[i] = cool_q[i] - CW'(1);
        end
        lfsr_d[i] = lfsr_next(lfsr_q[i]);
      end
    end
  end

  // State registers; reset reloads the fixed per-lane seeds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lfsr_q[i] <= seed_of(i);
        cool_q[i] <= '0;
      end
      press_q <= '0;
      fired_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        lfsr_q[i] <= lfsr_d[i];
        cool_q[i] <= cool_d[i];
      end
      press_q <= press_d;
      fired_q <= |press_d;
    end
  end

  assign bus.press_o = press_q;
  assign bus.fired_o = fired_q;
endmodule

// File: tb/tb_random_arrows.sv
// Self-checking bench for random_arrows: directed table for cooldown/cap,
// hand-written reset/enable/period sequences, and randomized traffic against
// a lane-level reference model.
module tb_random_arrows;
  localparam int unsigned W    = 9;
  localparam int unsigned N    = 4;
  localparam int          GAP  = 2;
  localparam int          MAXS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  random_arrows_if #(.LFSR_W(W), .NUM_CH(N)) bus  ();
  random_arrows_if #(.LFSR_W(W), .NUM_CH(N)) bus2 ();

  random_arrows dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  random_arrows #(.MAX_SIMUL(4), .GAP_MIN(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (lane-level, plain integers).
  int         m_lfsr [N];
  int         m_cool [N];
  logic [3:0] m_press;

  typedef struct {
    logic       st;
    logic       en;
    logic [8:0] thr;
    logic [3:0] exp_press;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int adv(input int v);
    int fb;
    fb = ((v >> 8) ^ (v >> 4)) & 1;
    return ((v << 1) | fb) & 'h1FF;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < N; c++) begin
      m_lfsr[c] = 'h0A5 ^ (c * 2);
      m_cool[c] = 0;
    end
    m_press = '0;
  endtask

  task automatic m_step(input int thr);
    int q[$];
    m_press = '0;
    for (int c = 0; c < N; c++)
      if (m_lfsr[c] < thr && m_cool[c] == 0) q.push_back(c);
    for (int c = 0; c < N; c++)
      if (m_cool[c] > 0) m_cool[c]--;
    for (int k = 0; k < q.size() && k < MAXS; k++) begin
      m_press[q[k]] = 1'b1;
      m_cool[q[k]]  = GAP;
    end
    for (int c = 0; c < N; c++) m_lfsr[c] = adv(m_lfsr[c]);
  endtask

  task automatic cyc(input logic st, input logic en, input logic [8:0] thr);
    bus.step_i = st; bus.enable_i = en; bus.threshold_i = thr;
    @(posedge clk); #1;
    if (st && en) m_step(int'(thr));
    else m_press = '0;
    chk("press", int'(bus.press_o), int'(m_press));
    chk("fired", int'(bus.fired_o), int'(m_press != 0));
  endtask

  task automatic do_reset();
    bus.step_i = 1'b0; bus2.step_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_press", int'(bus.press_o), 0);
    chk("reset_fired", int'(bus.fired_o), 0);
    rst = 1'b0;
    m_reset();
  endtask

  vec_t tbl [10];
  logic bad;

  initial begin
    rst = 1'b1;
    bus.enable_i = 1'b0; bus.step_i = 1'b0; bus.threshold_i = '0;
    bus2.enable_i = 1'b0; bus2.step_i = 1'b0; bus2.threshold_i = '0;
`ifdef RANDOM_ARROWS_SEED_LOAD_EN
    bus.seed_load_i = 1'b0;  bus.seed_in_i = '0;
    bus2.seed_load_i = 1'b0; bus2.seed_in_i = '0;
`endif
    #12;
    do_reset();

    // Single full-density step from seeds: lanes 0,1 win the cap of 2.
    cyc(1'b1, 1'b1, 9'h1FF);
    chk("t1_press", int'(bus.press_o), 'b0011);
    chk("t1_fired", int'(bus.fired_o), 1);
    cyc(1'b0, 1'b1, 9'h1FF);
    chk("t1_pulse_end", int'(bus.press_o), 0);

    // Threshold 0 never fires.
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 1'b1, 9'h000);
      if (bus.press_o != '0) bad = 1'b1;
    end
    chk("t2_thr0_silent", int'(bad), 0);

    // Cap=4 instance: cooldown pattern, enable-low steps ignored.
    tbl[0] = '{1'b1, 1'b1, 9'h1FF, 4'b1111};
    tbl[1] = '{1'b0, 1'b1, 9'h1FF, 4'b0000};
    tbl[2] = '{1'b1, 1'b1, 9'h1FF, 4'b0000};
    tbl[3] = '{1'b1, 1'b1, 9'h1FF, 4'b0000};
    tbl[4] = '{1'b1, 1'b1, 9'h1FF, 4'b1111};
    tbl[5] = '{1'b1, 1'b0, 9'h1FF, 4'b0000};
    tbl[6] = '{1'b1, 1'b0, 9'h1FF, 4'b0000};
    tbl[7] = '{1'b1, 1'b1, 9'h1FF, 4'b0000};
    tbl[8] = '{1'b1, 1'b1, 9'h1FF, 4'b0000};
    tbl[9] = '{1'b1, 1'b1, 9'h1FF, 4'b1111};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      bus2.step_i = tbl[k].st; bus2.enable_i = tbl[k].en; bus2.threshold_i = tbl[k].thr;
      @(posedge clk); #1;
      chk($sformatf("t3_vec%0d", k), int'(bus2.press_o), int'(tbl[k].exp_press));
      chk($sformatf("t3_fired%0d", k), int'(bus2.fired_o), int'(tbl[k].exp_press != 0));
    end
    bus2.step_i = 1'b0;

    // Full LFSR period: lane 0 returns to its seed and never hits zero.
    do_reset();
    bad = 1'b0;
    for (int k = 0; k < 511; k++) begin
      cyc(1'b1, 1'b1, 9'h1FF);
      if (dut.lfsr_q[0] == '0) bad = 1'b1;
    end
    chk("t4_never_zero", int'(bad), 0);
    chk("t4_period", int'(dut.lfsr_q[0]), 'h0A5);

    // Async reset mid-cycle, then replay from seeds; enable-low steps freeze state.
    do_reset();
    cyc(1'b1, 1'b1, 9'h1FF);
    cyc(1'b0, 1'b1, 9'h1FF);
    cyc(1'b0, 1'b1, 9'h1FF);
    cyc(1'b0, 1'b1, 9'h1FF);
    cyc(1'b1, 1'b1, 9'h1FF);
    chk("t5_second_step", int'(bus.press_o), 'b1100);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_press", int'(bus.press_o), 0);
    chk("t5_async_fired", int'(bus.fired_o), 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    cyc(1'b1, 1'b1, 9'h1FF);
    chk("t5_replay", int'(bus.press_o), 'b0011);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 9'h1FF);
    chk("t5_frozen_lfsr0", int'(dut.lfsr_q[0]), m_lfsr[0]);
    chk("t5_frozen_lfsr3", int'(dut.lfsr_q[3]), m_lfsr[3]);
    cyc(1'b1, 1'b1, 9'h1FF);
    cyc(1'b1, 1'b1, 9'h1FF);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic       st, en;
      logic [8:0] thr;
      int         r;
      st = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 4) != 0);
      r  = int'($urandom_range(0, 3));
      thr = (r == 0) ? 9'h000 : (r == 1) ? 9'h1FF : 9'($urandom);
      cyc(st, en, thr);
    end

`ifdef RANDOM_ARROWS_SEED_LOAD_EN
    // Seed load wins over a simultaneous step.
    do_reset();
    cyc(1'b1, 1'b1, 9'h1FF);
    bus.seed_load_i = 1'b1; bus.seed_in_i = 9'h002;
    bus.step_i = 1'b1; bus.enable_i = 1'b1; bus.threshold_i = 9'h1FF;
    @(posedge clk); #1;
    bus.seed_load_i = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_lfsr[c] = (2 ^ (c * 2)) | 1;
      m_cool[c] = 0;
    end
    m_press = '0;
    chk("t6_press", int'(bus.press_o), 0);
    chk("t6_lfsr0", int'(dut.lfsr_q[0]), 'h003);
    chk("t6_lfsr1", int'(dut.lfsr_q[1]), 'h001);
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 9'h100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
